// File: rtl/rr_onehot_arbiter_pkg.sv
// rtl/rr_onehot_arbiter_pkg.sv - shared types for the round-robin one-hot arbiter
package rr_onehot_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// rtl/rr_onehot_arbiter_if.sv - request/grant bundle between requesters, arbiter and encoder
interface rr_onehot_arbiter_if #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
);
  logic [N-1:0]     req;
  logic             clr;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [N-1:0]     gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     pend;
  logic             drop;

  modport master (
    output req, clr, gnt_ready,
    input  gnt_valid, gnt_onehot, gnt_idx, pend, drop
  );

  modport slave (
    input  req, clr, gnt_ready,
    output gnt_valid, gnt_onehot, gnt_idx, pend, drop
  );
endinterface

// File: rtl/rr_onehot_arbiter_pick.sv
// rtl/rr_onehot_arbiter_pick.sv - combinational round-robin pick of one pending bit after ptr
module rr_pick
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     pend,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0] rot;
  logic [N-1:0] lsb;
  int           shift;

  // Rotate so the line just after ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    shift  = (int'(ptr) == N - 1) ? 0 : int'(ptr) + 1;
    rot    = '0;
    onehot = '0;
    idx    = '0;
    for (int j = 0; j < N; j++) begin
      rot[IDX_W'(j)] = pend[IDX_W'((j + shift) % N)];
    end
    lsb = rot & (~rot + N'(1));
    for (int j = 0; j < N; j++) begin
      onehot[IDX_W'((j + shift) % N)] = lsb[IDX_W'(j)];
    end
    for (int j = 0; j < N; j++) begin
      if (onehot[IDX_W'(j)]) idx = IDX_W'(j);
    end
    any = |pend;
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - sticky request capture with round-robin one-hot grant over valid/ready
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_onehot_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(N);

  state_t           state;
  logic [N-1:0]     pend;
  logic [IDX_W-1:0] ptr;
  logic             gnt_valid;
  logic [N-1:0]     gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic             drop;

  logic [N-1:0]     pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic             accept;
  logic [N-1:0]     clear_vec;
  logic [N-1:0]     pend_next;
  logic             drop_next;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .pend   (pend),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // A new request on the line being accepted re-arms it rather than counting as lost.
  always_comb begin
    accept    = (state == ST_OFFER) && bus.gnt_ready;
    clear_vec = accept ? gnt_onehot : '0;
    pend_next = (pend & ~clear_vec) | bus.req;
    drop_next = |(bus.req & pend & ~clear_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pend       <= '0;
      ptr        <= IDX_W'(N - 1);
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
      drop       <= 1'b0;
    end else if (bus.clr) begin
      state      <= ST_IDLE;
      pend       <= '0;
      ptr        <= IDX_W'(N - 1);
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
      drop       <= 1'b0;
    end else begin
      pend <= pend_next;
      drop <= drop_next;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_onehot <= pick_onehot;
            gnt_idx    <= pick_idx;
            gnt_valid  <= 1'b1;
            state      <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (bus.gnt_ready) begin
            ptr        <= gnt_idx;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_idx    <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt_valid  = gnt_valid;
  assign bus.gnt_onehot = gnt_onehot;
  assign bus.gnt_idx    = gnt_idx;
  assign bus.pend       = pend;
  assign bus.drop       = drop;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - self-checking bench for rr_onehot_arbiter with N=4
module tb_rr_onehot_arbiter;

  localparam int NN = 4;

  logic          clk;
  logic          rst_n;
  logic [NN-1:0] req;
  logic          clr;
  logic          gnt_ready;

  int errors = 0;
  int checks = 0;

  // Reference state: pending lines as an integer bit set, offered line number, last granted line.
  int m_pend;
  bit m_valid;
  int m_idx;
  int m_ptr;
  bit m_drop;

  rr_onehot_arbiter_if #(.N(NN)) bus ();

  assign bus.req       = req;
  assign bus.clr       = clr;
  assign bus.gnt_ready = gnt_ready;

  rr_onehot_arbiter #(.N(NN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int next_line(input int pending, input int last);
    for (int k = 1; k <= NN; k++) begin
      int line;
      line = (last + k) % NN;
      if (((pending >> line) & 1) == 1) return line;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = NN - 1;
    m_drop  = 1'b0;
  endtask

  task automatic model_step();
    int old_pend;
    int taken;
    int line;
    if (clr) begin
      model_reset();
      return;
    end
    old_pend = m_pend;
    taken    = (m_valid && gnt_ready) ? m_idx : -1;
    m_drop   = 1'b0;
    for (int i = 0; i < NN; i++) begin
      bit has_req;
      bit was_pend;
      has_req  = req[i];
      was_pend = ((old_pend >> i) & 1) == 1;
      if (has_req) begin
        if (was_pend && taken != i) m_drop = 1'b1;
        m_pend = m_pend | (1 << i);
      end else if (taken == i) begin
        m_pend = m_pend & ~(1 << i);
      end
    end
    if (m_valid) begin
      if (gnt_ready) begin
        m_ptr   = m_idx;
        m_valid = 1'b0;
        m_idx   = 0;
      end
    end else begin
      line = next_line(old_pend, m_ptr);
      if (line >= 0) begin
        m_valid = 1'b1;
        m_idx   = line;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req       = '0;
    clr       = 1'b0;
    gnt_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b1111;
    clr       = 1'b0;
    gnt_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.gnt_valid); end
    checks++; if (bus.gnt_onehot !== 4'b0000) begin errors++; $display("FAIL reset_onehot: got %b want 0000", bus.gnt_onehot); end
    checks++; if (bus.gnt_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.gnt_idx); end
    checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b want 0000", bus.pend); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", bus.drop); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.pend !== 4'b1111) begin errors++; $display("FAIL reset_capture: got %b want 1111", bus.pend); end
    req = '0;
    tick();
    checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_onehot !== 4'b0001 || bus.gnt_idx !== 2'd0) begin
      errors++; $display("FAIL reset_first_grant: got v=%b oh=%b idx=%0d want v=1 oh=0001 idx=0", bus.gnt_valid, bus.gnt_onehot, bus.gnt_idx);
    end
  endtask

  task automatic test_round_robin();
    logic [NN-1:0] want;
    reset_dut();
    req = 4'b1111;
    gnt_ready = 1'b1;
    tick();
    req = '0;
    for (int k = 0; k < NN; k++) begin
      want = '0;
      want[k] = 1'b1;
      tick();
      checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_onehot !== want || bus.gnt_idx !== 2'(k)) begin
        errors++; $display("FAIL rr_grant%0d: got v=%b oh=%b idx=%0d want v=1 oh=%b idx=%0d", k, bus.gnt_valid, bus.gnt_onehot, bus.gnt_idx, want, k);
      end
      tick();
      checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got v=%b want 0", k, bus.gnt_valid); end
    end
    checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL rr_pend_empty: got %b want 0000", bus.pend); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_onehot !== 4'b0100 || bus.gnt_idx !== 2'd2) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b oh=%b idx=%0d want v=1 oh=0100 idx=2", k, bus.gnt_valid, bus.gnt_onehot, bus.gnt_idx);
      end
    end
    gnt_ready = 1'b1;
    tick();
    checks++; if (bus.pend !== 4'b0000 || bus.gnt_valid !== 1'b0) begin
      errors++; $display("FAIL bp_accept: got pend=%b v=%b want pend=0000 v=0", bus.pend, bus.gnt_valid);
    end
  endtask

  task automatic test_set_wins_drop();
    reset_dut();
    req = 4'b0011;
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    tick();
    checks++; if (bus.drop !== 1'b1 || bus.pend !== 4'b0011) begin
      errors++; $display("FAIL drop_pulse: got drop=%b pend=%b want drop=1 pend=0011", bus.drop, bus.pend);
    end
    req = '0;
    tick();
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL drop_one_cycle: got %b want 0", bus.drop); end
    gnt_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.gnt_onehot !== 4'b0010) begin errors++; $display("FAIL sw_grant1: got %b want 0010", bus.gnt_onehot); end
    req = 4'b0110;
    tick();
    checks++; if (bus.drop !== 1'b0 || bus.pend !== 4'b0110 || bus.gnt_valid !== 1'b0) begin
      errors++; $display("FAIL set_wins: got drop=%b pend=%b v=%b want drop=0 pend=0110 v=0", bus.drop, bus.pend, bus.gnt_valid);
    end
    req = '0;
    tick();
    checks++; if (bus.gnt_onehot !== 4'b0100) begin errors++; $display("FAIL sw_other_first: got %b want 0100", bus.gnt_onehot); end
    tick();
    tick();
    checks++; if (bus.gnt_onehot !== 4'b0010) begin errors++; $display("FAIL sw_regrant: got %b want 0010", bus.gnt_onehot); end
    tick();
  endtask

  task automatic test_wrap();
    reset_dut();
    gnt_ready = 1'b1;
    req = 4'b1100;
    tick();
    req = '0;
    tick();
    tick();
    tick();
    checks++; if (bus.gnt_onehot !== 4'b1000) begin errors++; $display("FAIL wrap_setup: got %b want 1000", bus.gnt_onehot); end
    req = 4'b1001;
    tick();
    req = '0;
    tick();
    checks++; if (bus.gnt_onehot !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b want 0001", bus.gnt_onehot); end
    tick();
    tick();
    checks++; if (bus.gnt_onehot !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
      errors++; $display("FAIL wrap_second: got oh=%b idx=%0d want oh=1000 idx=3", bus.gnt_onehot, bus.gnt_idx);
    end
    tick();
  endtask

  task automatic test_flush_reset();
    reset_dut();
    gnt_ready = 1'b1;
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    gnt_ready = 1'b0;
    req = 4'b0110;
    tick();
    req = '0;
    tick();
    checks++; if (bus.gnt_onehot !== 4'b0010) begin errors++; $display("FAIL flush_setup: got %b want 0010", bus.gnt_onehot); end
    clr = 1'b1;
    req = 4'b0001;
    gnt_ready = 1'b1;
    tick();
    clr = 1'b0;
    req = '0;
    gnt_ready = 1'b0;
    checks++; if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 4'b0000 || bus.pend !== 4'b0000 || bus.drop !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got v=%b oh=%b pend=%b drop=%b want all 0", bus.gnt_valid, bus.gnt_onehot, bus.pend, bus.drop);
    end
    req = 4'b0011;
    tick();
    req = '0;
    tick();
    checks++; if (bus.gnt_onehot !== 4'b0001) begin errors++; $display("FAIL flush_ptr: got %b want 0001", bus.gnt_onehot); end
    rst_n = 1'b0;
    #2;
    checks++; if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 4'b0000 || bus.pend !== 4'b0000) begin
      errors++; $display("FAIL async_reset: got v=%b oh=%b pend=%b want all 0", bus.gnt_valid, bus.gnt_onehot, bus.pend);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [NN-1:0] exp_oh;
    logic [1:0]    exp_idx;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      req       = 4'($urandom & $urandom);
      gnt_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      tick();
      exp_oh  = m_valid ? 4'(1 << m_idx) : 4'b0000;
      exp_idx = m_valid ? 2'(m_idx) : 2'd0;
      checks++;
      if (bus.gnt_valid !== m_valid || bus.gnt_onehot !== exp_oh || bus.gnt_idx !== exp_idx ||
          bus.pend !== 4'(m_pend) || bus.drop !== m_drop) begin
        errors++;
        $display("FAIL random_c%0d: got v=%b oh=%b idx=%0d pend=%b drop=%b want v=%b oh=%b idx=%0d pend=%b drop=%b",
                 c, bus.gnt_valid, bus.gnt_onehot, bus.gnt_idx, bus.pend, bus.drop,
                 m_valid, exp_oh, exp_idx, 4'(m_pend), m_drop);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_set_wins_drop();
    test_wrap();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
